// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 4-digit 7-segment driver for packed-BCD hours/minutes.
// Optional dp blinking is enabled by defining SEG_SCAN_BLINK_EN.
module bcd_seg_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hours,
    input  logic [7:0] minutes,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       digit_err
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          digit_err_q, digit_err_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic          frame_start, wrap, drive, blink_on;
    logic [3:0]    nibble;
    logic [3:0]    an_act;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b1000000;
        endcase
    endfunction

    function automatic logic out_of_range(input logic [7:0] h, input logic [7:0] m);
        out_of_range = (h[7:4] > 4'd9) || (h[3:0] > 4'd9) ||
                       (m[7:4] > 4'd9) || (m[3:0] > 4'd9) ||
                       (h > 8'h23) || (m > 8'h59);
    endfunction

`ifdef SEG_SCAN_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_q, blink_d;

    // Completed frames are counted on the idx 3 -> 0 wrap.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (wrap && (idx_q == 2'd3)) begin
            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign blink_on = blink_q;
`else
    assign blink_on = (BLINK_FRAMES > 0);
`endif

    always_comb begin
        frame_start = (pre_cnt_q == '0) && (idx_q == 2'd0);
        wrap        = (pre_cnt_q == PW'(SCAN_DIV - 1));
        pre_cnt_d   = wrap ? '0 : pre_cnt_q + PW'(1);
        idx_d       = wrap ? idx_q + 2'd1 : idx_q;

        shadow_d    = shadow_q;
        digit_err_d = digit_err_q;
        if (frame_start) begin
            shadow_d    = {hours, minutes};
            digit_err_d = out_of_range(hours, minutes);
        end

        // Slot 0 of every digit is blank so the previous digit cannot ghost.
        drive  = (pre_cnt_q != '0);
        nibble = shadow_q[{idx_q, 2'b00} +: 4];
        an_act = drive ? (4'b0001 << idx_q) : 4'b0000;
        if (blank_lz && (shadow_q[15:12] == 4'd0))
            an_act[3] = 1'b0;

        seg_d = decode(nibble) ^ {7{ACTIVE_LOW}};
        an_d  = an_act ^ {4{ACTIVE_LOW}};
        dp_d  = (drive && (idx_q == 2'd2) && blink_on) ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q   <= '0;
            idx_q       <= 2'd0;
            shadow_q    <= 16'h0000;
            digit_err_q <= 1'b0;
            seg_q       <= {7{ACTIVE_LOW}};
            dp_q        <= ACTIVE_LOW;
            an_q        <= {4{ACTIVE_LOW}};
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            digit_err_q <= digit_err_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign digit_err = digit_err_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed self-checking bench for bcd_seg_scan (SCAN_DIV=4, ACTIVE_LOW=1, BLINK_FRAMES=2).
module tb_bcd_seg_scan;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] hours = 8'h00;
    logic [7:0] minutes = 8'h00;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       digit_err;

    int checks = 0;
    int failures = 0;

    bcd_seg_scan #(
        .SCAN_DIV(4),
        .ACTIVE_LOW(1'b1),
        .BLINK_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hours(hours),
        .minutes(minutes),
        .blank_lz(blank_lz),
        .seg(seg),
        .dp(dp),
        .an(an),
        .digit_err(digit_err)
    );

    always #5 clk = ~clk;

    // Active-low segment patterns {g,f,e,d,c,b,a}; anything above 9 is '-'.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b0111111;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every test below starts and ends one cycle after a frame-start capture edge.
    task automatic test_reset();
        reset = 1'b1;
        tick(1);
        checks++;
        if (an !== 4'b1111) begin failures++; $display("[TB] FAIL reset_an got=%b exp=1111", an); end
        checks++;
        if (seg !== 7'b1111111) begin failures++; $display("[TB] FAIL reset_seg got=%b exp=1111111", seg); end
        checks++;
        if (dp !== 1'b1) begin failures++; $display("[TB] FAIL reset_dp got=%b exp=1", dp); end
        checks++;
        if (digit_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", digit_err); end
        hours = 8'h12;
        minutes = 8'h34;
        reset = 1'b0;
        tick(1);
        checks++;
        if (an !== 4'b1111) begin failures++; $display("[TB] FAIL first_blank_an got=%b exp=1111", an); end
    endtask

    task automatic test_basic();
        logic [15:0] shadow;
        logic [3:0]  exp_an;
        logic        exp_dp;
        int pre, idx;
        shadow = 16'h1234;
        for (int m = 1; m <= 16; m++) begin
            tick(1);
            pre = m % 4;
            idx = (m / 4) % 4;
            exp_an = (pre == 0) ? 4'b1111 : ~(4'b0001 << idx);
`ifdef SEG_SCAN_BLINK_EN
            exp_dp = 1'b1;
`else
            exp_dp = (pre != 0 && idx == 2) ? 1'b0 : 1'b1;
`endif
            checks++;
            if (an !== exp_an) begin failures++; $display("[TB] FAIL basic_an m=%0d got=%b exp=%b", m, an, exp_an); end
            checks++;
            if (dp !== exp_dp) begin failures++; $display("[TB] FAIL basic_dp m=%0d got=%b exp=%b", m, dp, exp_dp); end
            checks++;
            if (digit_err !== 1'b0) begin failures++; $display("[TB] FAIL basic_err m=%0d got=%b exp=0", m, digit_err); end
            if (pre != 0) begin
                checks++;
                if (seg !== seg_of(shadow[idx*4 +: 4]))
                    begin failures++; $display("[TB] FAIL basic_seg m=%0d got=%b exp=%b", m, seg, seg_of(shadow[idx*4 +: 4])); end
            end
        end
    endtask

    task automatic test_leading_zero();
        hours = 8'h07;
        minutes = 8'h34;
        blank_lz = 1'b1;
        tick(16);
        tick(13);
        checks++;
        if (an !== 4'b1111) begin failures++; $display("[TB] FAIL lz_on_an got=%b exp=1111", an); end
        tick(2);
        checks++;
        if (an !== 4'b1111) begin failures++; $display("[TB] FAIL lz_on_an_late got=%b exp=1111", an); end
        tick(1);
        blank_lz = 1'b0;
        tick(13);
        checks++;
        if (an !== 4'b0111) begin failures++; $display("[TB] FAIL lz_off_an got=%b exp=0111", an); end
        checks++;
        if (seg !== 7'b1000000) begin failures++; $display("[TB] FAIL lz_off_seg got=%b exp=1000000", seg); end
        tick(3);
    endtask

    task automatic test_no_tearing();
        hours = 8'h12;
        minutes = 8'h34;
        tick(16);
        tick(5);
        hours = 8'h09;
        minutes = 8'h35;
        tick(4);
        checks++;
        if (seg !== seg_of(4'd2)) begin failures++; $display("[TB] FAIL tear_d2_seg got=%b exp=%b", seg, seg_of(4'd2)); end
        tick(4);
        checks++;
        if (seg !== seg_of(4'd1)) begin failures++; $display("[TB] FAIL tear_d3_seg got=%b exp=%b", seg, seg_of(4'd1)); end
        tick(3);
        tick(1);
        checks++;
        if (seg !== seg_of(4'd5) || an !== 4'b1110)
            begin failures++; $display("[TB] FAIL tear_next_d0 got seg=%b an=%b exp seg=%b an=1110", seg, an, seg_of(4'd5)); end
        tick(12);
        checks++;
        if (seg !== seg_of(4'd0)) begin failures++; $display("[TB] FAIL tear_next_d3 got=%b exp=%b", seg, seg_of(4'd0)); end
        tick(3);
    endtask

    task automatic test_range_error();
        hours = 8'h12;
        minutes = 8'h6A;
        tick(16);
        checks++;
        if (digit_err !== 1'b1) begin failures++; $display("[TB] FAIL err_6a got=%b exp=1", digit_err); end
        tick(1);
        checks++;
        if (seg !== 7'b0111111 || an !== 4'b1110)
            begin failures++; $display("[TB] FAIL err_dash got seg=%b an=%b exp seg=0111111 an=1110", seg, an); end
        minutes = 8'h59;
        tick(14);
        checks++;
        if (digit_err !== 1'b1) begin failures++; $display("[TB] FAIL err_hold got=%b exp=1", digit_err); end
        tick(1);
        checks++;
        if (digit_err !== 1'b0) begin failures++; $display("[TB] FAIL err_clear got=%b exp=0", digit_err); end
        hours = 8'h24;
        tick(16);
        checks++;
        if (digit_err !== 1'b1) begin failures++; $display("[TB] FAIL err_h24 got=%b exp=1", digit_err); end
        hours = 8'h23;
        tick(16);
        checks++;
        if (digit_err !== 1'b0) begin failures++; $display("[TB] FAIL err_2359 got=%b exp=0", digit_err); end
    endtask

    task automatic test_decode();
        logic [15:0] vecs [2];
        logic [15:0] v;
        vecs[0] = 16'h5678;
        vecs[1] = 16'h9012;
        for (int k = 0; k < 2; k++) begin
            v = vecs[k];
            hours = v[15:8];
            minutes = v[7:0];
            tick(16);
            tick(2);
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (seg !== seg_of(v[d*4 +: 4]))
                    begin failures++; $display("[TB] FAIL decode v=%h d=%0d got=%b exp=%b", v, d, seg, seg_of(v[d*4 +: 4])); end
                if (d < 3) tick(4);
            end
            tick(2);
        end
    endtask

    task automatic test_reset_mid();
        hours = 8'h12;
        minutes = 8'h6A;
        tick(16);
        checks++;
        if (digit_err !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_err got=%b exp=1", digit_err); end
        tick(9);
        reset = 1'b1;
        tick(1);
        checks++;
        if (an !== 4'b1111) begin failures++; $display("[TB] FAIL mid_an got=%b exp=1111", an); end
        checks++;
        if (seg !== 7'b1111111) begin failures++; $display("[TB] FAIL mid_seg got=%b exp=1111111", seg); end
        checks++;
        if (dp !== 1'b1) begin failures++; $display("[TB] FAIL mid_dp got=%b exp=1", dp); end
        checks++;
        if (digit_err !== 1'b0) begin failures++; $display("[TB] FAIL mid_err got=%b exp=0", digit_err); end
        minutes = 8'h34;
        reset = 1'b0;
        tick(1);
        checks++;
        if (an !== 4'b1111) begin failures++; $display("[TB] FAIL mid_restart_blank got=%b exp=1111", an); end
        tick(1);
        checks++;
        if (an !== 4'b1110 || seg !== seg_of(4'd4))
            begin failures++; $display("[TB] FAIL mid_restart_d0 got an=%b seg=%b exp an=1110 seg=%b", an, seg, seg_of(4'd4)); end
        tick(15);
    endtask

    task automatic test_dp();
        logic exp_dp;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        for (int f = 0; f < 6; f++) begin
            tick(1);
            checks++;
            if (dp !== 1'b1) begin failures++; $display("[TB] FAIL dp_idx0 f=%0d got=%b exp=1", f, dp); end
            tick(8);
`ifdef SEG_SCAN_BLINK_EN
            exp_dp = ((f / 2) % 2 == 1) ? 1'b0 : 1'b1;
`else
            exp_dp = 1'b0;
`endif
            checks++;
            if (dp !== exp_dp) begin failures++; $display("[TB] FAIL dp_idx2 f=%0d got=%b exp=%b", f, dp, exp_dp); end
            tick(7);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tick(2);
        test_reset();
        test_basic();
        test_leading_zero();
        test_no_tearing();
        test_range_error();
        test_decode();
        test_reset_mid();
        test_dp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
